// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Generates load-enable and bubble-flush controls for the PC and every
// inter-stage register bank, PC redirects for jumps and traps, WFI sleep
// handling, per-stage valid tracking and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int AW = 32,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_valid,
    input  logic          id_load_use,
    input  logic          ex_mdu_busy,
    input  logic          ex_jump,
    input  logic [AW-1:0] ex_jump_addr,
    input  logic          ex_wfi,
    input  logic          mem_wait,
    input  logic          trap_req,
    input  logic [AW-1:0] trap_vec,
    input  logic          irq_pending,
    output logic          pc_wr_en,
    output logic          if_id_wr_en,
    output logic          id_ex_wr_en,
    output logic          ex_mem_wr_en,
    output logic          mem_wb_wr_en,
    output logic          if_id_flush,
    output logic          id_ex_flush,
    output logic          ex_mem_flush,
    output logic          mem_wb_flush,
    output logic          redirect_valid,
    output logic [AW-1:0] redirect_addr,
    output logic          id_valid,
    output logic          ex_valid,
    output logic          mem_valid,
    output logic          wb_valid,
    output logic [CW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WFI  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic          v_id_r;
    logic          v_ex_r;
    logic          v_mem_r;
    logic          v_wb_r;
    logic [CW-1:0] stall_cnt_r;

    logic          pc_we_s;
    logic          if_id_we_s;
    logic          id_ex_we_s;
    logic          ex_mem_we_s;
    logic          mem_wb_we_s;
    logic          if_id_fl_s;
    logic          id_ex_fl_s;
    logic          ex_mem_fl_s;
    logic          mem_wb_fl_s;
    logic          redir_v_s;
    logic [AW-1:0] redir_a_s;
    // The WFI moves on into MEM while ID/EX is frozen; the frozen EX copy
    // must be marked empty so it is not executed a second time on wake-up.
    logic          wfi_retire_s;

    // Next-state and per-cycle control decode (priority-ordered in RUN).
    always_comb begin
        pc_we_s      = 1'b1;
        if_id_we_s   = 1'b1;
        id_ex_we_s   = 1'b1;
        ex_mem_we_s  = 1'b1;
        mem_wb_we_s  = 1'b1;
        if_id_fl_s   = 1'b0;
        id_ex_fl_s   = 1'b0;
        ex_mem_fl_s  = 1'b0;
        mem_wb_fl_s  = 1'b0;
        redir_v_s    = 1'b0;
        redir_a_s    = {AW{1'b0}};
        wfi_retire_s = 1'b0;
        state_nxt_s  = state_r;
        if (rst) begin
            // Every bank loads a bubble while reset is held.
            if_id_fl_s  = 1'b1;
            id_ex_fl_s  = 1'b1;
            ex_mem_fl_s = 1'b1;
            mem_wb_fl_s = 1'b1;
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (trap_req && v_mem_r) begin
                        if_id_fl_s  = 1'b1;
                        id_ex_fl_s  = 1'b1;
                        ex_mem_fl_s = 1'b1;
                        mem_wb_fl_s = 1'b1;
                        redir_v_s   = 1'b1;
                        redir_a_s   = trap_vec;
                        state_nxt_s = ST_TRAP;
                    end else if (mem_wait) begin
                        // Any jump/WFI in EX is simply held until MEM frees up.
                        pc_we_s     = 1'b0;
                        if_id_we_s  = 1'b0;
                        id_ex_we_s  = 1'b0;
                        ex_mem_we_s = 1'b0;
                        mem_wb_fl_s = 1'b1;
                    end else if (ex_jump && v_ex_r) begin
                        if_id_fl_s = 1'b1;
                        id_ex_fl_s = 1'b1;
                        redir_v_s  = 1'b1;
                        redir_a_s  = ex_jump_addr;
                    end else if (ex_wfi && v_ex_r && !irq_pending) begin
                        pc_we_s      = 1'b0;
                        if_id_we_s   = 1'b0;
                        id_ex_we_s   = 1'b0;
                        wfi_retire_s = 1'b1;
                        state_nxt_s  = ST_WFI;
                    end else if (ex_mdu_busy && v_ex_r) begin
                        pc_we_s     = 1'b0;
                        if_id_we_s  = 1'b0;
                        id_ex_we_s  = 1'b0;
                        ex_mem_we_s = 1'b0;
                        mem_wb_fl_s = 1'b1;
                    end else if (id_load_use && v_id_r && v_ex_r) begin
                        pc_we_s    = 1'b0;
                        if_id_we_s = 1'b0;
                        id_ex_fl_s = 1'b1;
                    end else begin
                        // Normal advance: the defaults above already apply.
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_WFI: begin
                    if (irq_pending) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        // Front end frozen while EX/MEM/WB drain to bubbles.
                        pc_we_s     = 1'b0;
                        if_id_we_s  = 1'b0;
                        id_ex_we_s  = 1'b0;
                        ex_mem_fl_s = 1'b1;
                        mem_wb_fl_s = 1'b1;
                    end
                end
                ST_TRAP: begin
                    // Refill guard after a trap: squash everything once more.
                    if_id_fl_s  = 1'b1;
                    id_ex_fl_s  = 1'b1;
                    ex_mem_fl_s = 1'b1;
                    mem_wb_fl_s = 1'b1;
                    state_nxt_s = ST_RUN;
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // FSM state and per-stage valid bits follow the bank load controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            v_id_r  <= 1'b0;
            v_ex_r  <= 1'b0;
            v_mem_r <= 1'b0;
            v_wb_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (if_id_we_s) begin
                v_id_r <= if_valid & ~if_id_fl_s;
            end
            if (id_ex_we_s) begin
                v_ex_r <= v_id_r & ~id_ex_fl_s;
            end else if (wfi_retire_s) begin
                v_ex_r <= 1'b0;
            end
            if (ex_mem_we_s) begin
                v_mem_r <= v_ex_r & ~ex_mem_fl_s;
            end
            if (mem_wb_we_s) begin
                v_wb_r <= v_mem_r & ~mem_wb_fl_s;
            end
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CW{1'b0}};
        end else if (!pc_we_s && (stall_cnt_r != {CW{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign pc_wr_en       = pc_we_s;
    assign if_id_wr_en    = if_id_we_s;
    assign id_ex_wr_en    = id_ex_we_s;
    assign ex_mem_wr_en   = ex_mem_we_s;
    assign mem_wb_wr_en   = mem_wb_we_s;
    assign if_id_flush    = if_id_fl_s;
    assign id_ex_flush    = id_ex_fl_s;
    assign ex_mem_flush   = ex_mem_fl_s;
    assign mem_wb_flush   = mem_wb_fl_s;
    assign redirect_valid = redir_v_s;
    assign redirect_addr  = redir_a_s;
    assign id_valid       = v_id_r;
    assign ex_valid       = v_ex_r;
    assign mem_valid      = v_mem_r;
    assign wb_valid       = v_wb_r;
    assign stall_cnt      = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expectations are queued as each step is
// driven and popped/compared while that step's outputs are present.
module tb_pipe_ctrl;

    localparam int AW = 32;

    localparam int S_WE   = 0;  // {pc,if_id,id_ex,ex_mem,mem_wb} wr_en
    localparam int S_FL   = 1;  // {if_id,id_ex,ex_mem,mem_wb} flush
    localparam int S_RV   = 2;
    localparam int S_RA   = 3;
    localparam int S_V    = 4;  // {id,ex,mem,wb} valid
    localparam int S_CNT  = 5;
    localparam int S_CNT4 = 6;
    localparam int S_WE4  = 7;
    localparam int S_MSC4 = 8;  // {flush[3:0], redirect_valid, valid[3:0]}
    localparam int S_RA4  = 9;

    logic          clk = 1'b0;
    logic          rst, if_valid, id_load_use, ex_mdu_busy, ex_jump, ex_wfi;
    logic          mem_wait, trap_req, irq_pending;
    logic [AW-1:0] ex_jump_addr, trap_vec;

    logic          pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en;
    logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic          redirect_valid, id_valid, ex_valid, mem_valid, wb_valid;
    logic [AW-1:0] redirect_addr;
    logic [31:0]   stall_cnt;

    logic          d4_pc_we, d4_ifid_we, d4_idex_we, d4_exmem_we, d4_memwb_we;
    logic          d4_ifid_fl, d4_idex_fl, d4_exmem_fl, d4_memwb_fl;
    logic          d4_rv, d4_vid, d4_vex, d4_vmem, d4_vwb;
    logic [AW-1:0] d4_ra;
    logic [3:0]    d4_cnt;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.AW(AW), .CW(32)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .id_load_use(id_load_use),
        .ex_mdu_busy(ex_mdu_busy), .ex_jump(ex_jump), .ex_jump_addr(ex_jump_addr),
        .ex_wfi(ex_wfi), .mem_wait(mem_wait), .trap_req(trap_req), .trap_vec(trap_vec),
        .irq_pending(irq_pending), .pc_wr_en(pc_wr_en), .if_id_wr_en(if_id_wr_en),
        .id_ex_wr_en(id_ex_wr_en), .ex_mem_wr_en(ex_mem_wr_en), .mem_wb_wr_en(mem_wb_wr_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .id_valid(id_valid), .ex_valid(ex_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.AW(AW), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .id_load_use(id_load_use),
        .ex_mdu_busy(ex_mdu_busy), .ex_jump(ex_jump), .ex_jump_addr(ex_jump_addr),
        .ex_wfi(ex_wfi), .mem_wait(mem_wait), .trap_req(trap_req), .trap_vec(trap_vec),
        .irq_pending(irq_pending), .pc_wr_en(d4_pc_we), .if_id_wr_en(d4_ifid_we),
        .id_ex_wr_en(d4_idex_we), .ex_mem_wr_en(d4_exmem_we), .mem_wb_wr_en(d4_memwb_we),
        .if_id_flush(d4_ifid_fl), .id_ex_flush(d4_idex_fl), .ex_mem_flush(d4_exmem_fl),
        .mem_wb_flush(d4_memwb_fl), .redirect_valid(d4_rv), .redirect_addr(d4_ra),
        .id_valid(d4_vid), .ex_valid(d4_vex), .mem_valid(d4_vmem), .wb_valid(d4_vwb),
        .stall_cnt(d4_cnt)
    );

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_WE:    return {27'd0, pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en};
            S_FL:    return {28'd0, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
            S_RV:    return {31'd0, redirect_valid};
            S_RA:    return redirect_addr;
            S_V:     return {28'd0, id_valid, ex_valid, mem_valid, wb_valid};
            S_CNT:   return stall_cnt;
            S_CNT4:  return {28'd0, d4_cnt};
            S_WE4:   return {27'd0, d4_pc_we, d4_ifid_we, d4_idex_we, d4_exmem_we, d4_memwb_we};
            S_MSC4:  return {23'd0, d4_ifid_fl, d4_idex_fl, d4_exmem_fl, d4_memwb_fl, d4_rv,
                             d4_vid, d4_vex, d4_vmem, d4_vwb};
            S_RA4:   return d4_ra;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic exp_push(input string tag, input int sig, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] o;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sig);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, o, e.exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; id_load_use = 1'b0; ex_mdu_busy = 1'b0;
        ex_jump = 1'b0; ex_wfi = 1'b0; mem_wait = 1'b0; trap_req = 1'b0;
        irq_pending = 1'b0; ex_jump_addr = 32'h0; trap_vec = 32'h0;

        // Reset held for three cycles: every bank loads bubbles, no redirect.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_push("rst_we", S_WE, 32'h1F);
            exp_push("rst_fl", S_FL, 32'hF);
            exp_push("rst_rv", S_RV, 32'h0);
            exp_push("rst_ra", S_RA, 32'h0);
            check_all();
        end
        @(negedge clk); rst = 1'b0; if_valid = 1'b1;
        exp_push("post_rst_v", S_V, 32'h0);
        exp_push("post_rst_cnt", S_CNT, 32'd0);
        exp_push("run_we", S_WE, 32'h1F);
        exp_push("run_fl", S_FL, 32'h0);
        check_all();
        @(negedge clk); exp_push("fill_id", S_V, 32'h8); check_all();
        @(negedge clk); exp_push("fill_ex", S_V, 32'hC); check_all();
        @(negedge clk); exp_push("fill_mem", S_V, 32'hE); check_all();

        // Load-use: one bubble into EX.
        @(negedge clk); id_load_use = 1'b1;
        exp_push("lu_v_full", S_V, 32'hF);
        exp_push("lu_we", S_WE, 32'h07);
        exp_push("lu_fl", S_FL, 32'h4);
        exp_push("lu_cnt0", S_CNT, 32'd0);
        check_all();
        @(negedge clk); id_load_use = 1'b0;
        exp_push("lu_bubble_v", S_V, 32'hB);
        exp_push("lu_cnt1", S_CNT, 32'd1);
        check_all();
        @(negedge clk); exp_push("lu_bubble_mem", S_V, 32'hD); check_all();

        // Jump held under mem_wait for two cycles, then taken.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); ex_jump = 1'b1; ex_jump_addr = 32'h8000_0100; mem_wait = 1'b1;
            exp_push("jw_we", S_WE, 32'h01);
            exp_push("jw_fl", S_FL, 32'h1);
            exp_push("jw_rv", S_RV, 32'h0);
            exp_push("jw_ra", S_RA, 32'h0);
            exp_push("jw_cnt", S_CNT, 32'd1 + 32'(i));
            exp_push("jw_v_hold", S_V, (i == 0) ? 32'hE : 32'hE);
            check_all();
        end
        @(negedge clk); mem_wait = 1'b0;
        exp_push("jmp_rv", S_RV, 32'h1);
        exp_push("jmp_ra", S_RA, 32'h8000_0100);
        exp_push("jmp_we", S_WE, 32'h1F);
        exp_push("jmp_fl", S_FL, 32'hC);
        exp_push("jmp_cnt", S_CNT, 32'd3);
        check_all();
        @(negedge clk); ex_jump = 1'b0;
        exp_push("jmp_bubbles1", S_V, 32'h3);
        check_all();
        @(negedge clk); exp_push("jmp_bubbles2", S_V, 32'h9); check_all();
        repeat (2) @(negedge clk);

        // Trap and jump in the same cycle: trap wins, then the guard cycle.
        @(negedge clk); trap_req = 1'b1; trap_vec = 32'h8000_0004; ex_jump = 1'b1;
        exp_push("trap_v_full", S_V, 32'hF);
        exp_push("trap_rv", S_RV, 32'h1);
        exp_push("trap_ra", S_RA, 32'h8000_0004);
        exp_push("trap_we", S_WE, 32'h1F);
        exp_push("trap_fl", S_FL, 32'hF);
        check_all();
        @(negedge clk);
        exp_push("guard_v", S_V, 32'h0);
        exp_push("guard_rv", S_RV, 32'h0);
        exp_push("guard_ra", S_RA, 32'h0);
        exp_push("guard_we", S_WE, 32'h1F);
        exp_push("guard_fl", S_FL, 32'hF);
        check_all();
        @(negedge clk); trap_req = 1'b0; ex_jump = 1'b0;
        exp_push("after_trap_fl", S_FL, 32'h0);
        exp_push("after_trap_rv", S_RV, 32'h0);
        check_all();
        repeat (3) @(negedge clk);

        // WFI with no pending interrupt: sleep five cycles, drain, wake.
        @(negedge clk); ex_wfi = 1'b1;
        exp_push("wfi_v_full", S_V, 32'hF);
        exp_push("wfi_we", S_WE, 32'h03);
        exp_push("wfi_fl", S_FL, 32'h0);
        exp_push("wfi_cnt", S_CNT, 32'd3);
        check_all();
        @(negedge clk); ex_wfi = 1'b0;
        exp_push("wfi_s1_v", S_V, 32'hB);
        exp_push("wfi_s1_we", S_WE, 32'h03);
        exp_push("wfi_s1_fl", S_FL, 32'h3);
        exp_push("wfi_s1_cnt", S_CNT, 32'd4);
        check_all();
        for (int j = 2; j < 5; j++) begin
            @(negedge clk);
            exp_push("wfi_drained_v", S_V, 32'h8);
            exp_push("wfi_sleep_we", S_WE, 32'h03);
            exp_push("wfi_sleep_cnt", S_CNT, 32'd3 + 32'(j));
            check_all();
        end
        @(negedge clk); irq_pending = 1'b1;
        exp_push("wake_we", S_WE, 32'h1F);
        exp_push("wake_fl", S_FL, 32'h0);
        exp_push("wake_cnt", S_CNT, 32'd8);
        check_all();
        @(negedge clk); irq_pending = 1'b0;
        exp_push("wake_v", S_V, 32'hC);
        exp_push("wake_run_we", S_WE, 32'h1F);
        check_all();

        // WFI with interrupt already pending behaves as a NOP.
        @(negedge clk); ex_wfi = 1'b1; irq_pending = 1'b1;
        exp_push("wfinop_v", S_V, 32'hE);
        exp_push("wfinop_we", S_WE, 32'h1F);
        exp_push("wfinop_fl", S_FL, 32'h0);
        check_all();
        @(negedge clk); ex_wfi = 1'b0; irq_pending = 1'b0;
        exp_push("wfinop_we2", S_WE, 32'h1F);
        exp_push("wfinop_cnt", S_CNT, 32'd8);
        check_all();

        // Enter WFI, then reset: must come back in RUN.
        @(negedge clk); ex_wfi = 1'b1;
        exp_push("wfi2_we", S_WE, 32'h03);
        check_all();
        @(negedge clk); ex_wfi = 1'b0; rst = 1'b1;
        exp_push("rst_wfi_we", S_WE, 32'h1F);
        exp_push("rst_wfi_fl", S_FL, 32'hF);
        exp_push("rst_wfi_rv", S_RV, 32'h0);
        check_all();

        // mem_wait for 20 cycles: 32-bit counter counts, 4-bit one saturates.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); rst = 1'b0; if_valid = 1'b0; mem_wait = 1'b1;
            exp_push("sat_cnt32", S_CNT, 32'(i));
            exp_push("sat_cnt4", S_CNT4, (i < 15) ? 32'(i) : 32'd15);
            exp_push("sat_we", S_WE, 32'h01);
            exp_push("sat_we4", S_WE4, 32'h01);
            exp_push("sat_misc4", S_MSC4, 32'h020);
            exp_push("sat_ra4", S_RA4, 32'h0);
            if (i == 0) begin
                exp_push("sat_v", S_V, 32'h0);
            end
            check_all();
        end
        @(negedge clk); mem_wait = 1'b0;
        exp_push("sat_end_cnt32", S_CNT, 32'd20);
        exp_push("sat_end_cnt4", S_CNT4, 32'd15);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
